// File: rtl/adder_3bit_accum_ctrl.sv
// adder_3bit_accum_ctrl
//
// Sequential control stage around the team's combinational 3-bit adder.
// Operands arrive on a valid/ready stream. Each accepted operand is added to
// a running accumulator through the external adder. After FRAME_LEN operands
// the final 3-bit sum and a saturating count of adder carry-outs are offered
// on a valid/ready result port.
//
// Parameters:
//   FRAME_LEN  operands per frame (1..15)
//   OVF_W      width of the carry-out counter
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_ready     operand handshake, in_data is the 3-bit operand
//   add_a/add_b           to adder: accumulator operand / incoming operand
//   add_sum/add_cout      from adder: sum and carry-out (same cycle)
//   out_valid/out_ready   frame result handshake
//   out_sum/out_ovf       frame final sum / number of carry-outs
//   busy                  frame in progress or result pending
//
// Optional feature (macro ADDER_3BIT_ACCUM_SATURATE_EN): an accept whose
// addition carries out loads 3'b111 into the accumulator instead of the
// wrapped sum. The carry-out count is unaffected.

module adder_3bit_accum_ctrl #(
    parameter int FRAME_LEN = 4,
    parameter int OVF_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_data,
    output logic [2:0]       add_a,
    output logic [2:0]       add_b,
    input  logic [2:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sum,
    output logic [OVF_W-1:0] out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]       FRAME_LEN_C = 4'(FRAME_LEN);
    localparam logic [OVF_W-1:0] OVF_MAX     = '1;

    state_t           state_q, state_d;
    logic [2:0]       acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic [2:0]       outSum_q, outSum_d;
    logic [OVF_W-1:0] outOvf_q, outOvf_d;
    logic             outValid_q, outValid_d;

    logic             accept;
    logic [2:0]       accNext;
    logic [OVF_W-1:0] ovfNext;

    // Ready is forced low during reset so nothing upstream sees a handshake
    // while the block is held in reset.
    assign in_ready  = !rst && (state_q != DONE);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign out_sum   = outSum_q;
    assign out_ovf   = outOvf_q;

    // The first operand of a frame is added to zero, whatever acc holds.
    assign add_a = (state_q == IDLE) ? 3'b000 : acc_q;
    assign add_b = in_data;

`ifdef ADDER_3BIT_ACCUM_SATURATE_EN
    // A carry-out pins the accumulator at its maximum.
    assign accNext = add_cout ? 3'b111 : add_sum;
`else
    // Plain 3-bit wrap; the lost carry is only recorded in ovf.
    assign accNext = add_sum;
`endif

    // Carry counter sticks at all-ones once full.
    assign ovfNext = (add_cout && (ovf_q != OVF_MAX)) ? (ovf_q + OVF_W'(1)) : ovf_q;

    // Next-state logic: accumulate while a frame is open, publish the result
    // on the final beat, and clear the frame on the result handshake.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        outSum_d   = outSum_q;
        outOvf_d   = outOvf_q;
        outValid_d = outValid_q;

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = accNext;
                    ovf_d = ovfNext;
                    cnt_d = cnt_q + 4'd1;
                    if ((cnt_q + 4'd1) == FRAME_LEN_C) begin
                        state_d    = DONE;
                        outSum_d   = accNext;
                        outOvf_d   = ovfNext;
                        outValid_d = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            DONE: begin
                // out_valid is always high here, so out_ready alone completes
                // the handshake. The published result stays on the outputs.
                if (out_ready) begin
                    state_d    = IDLE;
                    outValid_d = 1'b0;
                    acc_d      = 3'b000;
                    cnt_d      = 4'd0;
                    ovf_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= 3'b000;
            cnt_q      <= 4'd0;
            ovf_q      <= '0;
            outSum_q   <= 3'b000;
            outOvf_q   <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            outSum_q   <= outSum_d;
            outOvf_q   <= outOvf_d;
            outValid_q <= outValid_d;
        end
    end

endmodule
